// File: rtl/mcs_wait_bridge.sv
// mcs_wait_bridge: MicroBlaze MCS I/O bus to basic wait-state bus bridge.
// Each transaction runs until the slave acknowledges or the cycle budget runs out.
module mcs_wait_bridge #(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int NUM_CS = 2,
  parameter int ADDR_W = 21,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_addr_strobe,
  input  logic              io_read_strobe,
  input  logic              io_write_strobe,
  input  logic [3:0]        io_byte_enable,
  input  logic [31:0]       io_address,
  input  logic [31:0]       io_write_data,
  output logic [31:0]       io_read_data,
  output logic              io_ready,
  output logic [NUM_CS-1:0] b_cs,
  output logic              b_wr,
  output logic              b_rd,
  output logic [3:0]        b_be,
  output logic [ADDR_W-1:0] b_addr,
  output logic [31:0]       b_wr_data,
  input  logic [31:0]       b_rd_data,
  input  logic              b_ack,
  output logic [7:0]        timeout_cnt
);
  localparam int SW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr;
  logic [SW-1:0] slot;
  logic [3:0] be;
  logic [31:0] wdata;
  logic wr;
  logic [7:0] cnt;
  logic strobe, hit, busy, expire;
  logic unused;
  assign unused = ^{io_addr_strobe, io_address};
  assign strobe = io_write_strobe | io_read_strobe;
  assign hit = io_address[31:24] == BRG_BASE[31:24];
  assign busy = state == ACCESS || state == WAIT;
  // cnt holds the 1-based index of the current ACCESS/WAIT cycle
  assign expire = cnt == 8'(TIMEOUT);
  always_comb begin
    next = state;
    next = state == IDLE ? (strobe ? (hit ? ACCESS : DONE) : IDLE)
         : busy ? (b_ack || expire ? DONE : WAIT)
         : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      slot <= '0;
      be <= '0;
      wdata <= '0;
      wr <= 1'b0;
      cnt <= '0;
      io_read_data <= '0;
      timeout_cnt <= '0;
    end else if (state == IDLE && strobe) begin
      addr <= io_address[ADDR_W+1:2];
      slot <= NUM_CS == 1 ? '0 : io_address[23 -: SW];
      be <= io_byte_enable;
      wdata <= io_write_data;
      wr <= io_write_strobe;
      cnt <= 8'd1;
      if (!hit) io_read_data <= '0;
    end else if (busy) begin
      cnt <= cnt + 8'd1;
      if (!wr && b_ack) io_read_data <= b_rd_data;
      else if (!wr && expire) io_read_data <= 32'hDEAD_BEEF;
      if (!b_ack && expire && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  assign b_cs = busy ? NUM_CS'(1) << slot : '0;
  assign b_wr = state == ACCESS && wr;
  assign b_rd = state == ACCESS && !wr;
  assign b_be = busy ? be : '0;
  assign b_addr = busy ? addr : '0;
  assign b_wr_data = busy ? wdata : '0;
  assign io_ready = state == DONE;
endmodule

// File: doc/mcs_wait_bridge.md
MCS_WAIT_BRIDGE -- requirements
Module: mcs_wait_bridge

Interface
REQ-001 SHALL have parameter BRG_BASE, default 32'hC000_0000, bridge base address; only bits [31:24] are decoded.
REQ-002 SHALL have parameter NUM_CS, default 2, number of slave chip selects; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter ADDR_W, default 21, width of the word address on the basic bus.
REQ-004 SHALL have parameter TIMEOUT, default 16, the maximum number of bus cycles allowed without acknowledge; legal range 2-255.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all flops use its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have ports io_addr_strobe, io_read_strobe and io_write_strobe, each input, 1 bit, the uBlaze MCS I/O strobes; io_addr_strobe is unused.
REQ-008 SHALL have ports io_byte_enable (input, 4 bits), io_address (input, 32 bits) and io_write_data (input, 32 bits).
REQ-009 SHALL have ports io_read_data (output, 32 bits) and io_ready (output, 1 bit), the MCS response.
REQ-010 SHALL have ports b_cs (output, NUM_CS bits), b_wr (output, 1 bit), b_rd (output, 1 bit) and b_be (output, 4 bits), the basic-bus controls.
REQ-011 SHALL have ports b_addr (output, ADDR_W bits), b_wr_data (output, 32 bits) and b_rd_data (input, 32 bits).
REQ-012 SHALL have port b_ack, input, 1 bit, the slave completion acknowledge.
REQ-013 SHALL have port timeout_cnt, output, 8 bits, a saturating count of timed-out transactions.

Function
REQ-014 SHALL define a hit as io_address[31:24]==BRG_BASE[31:24], slot = io_address[23 -: log2(NUM_CS)] (slot 0 when NUM_CS=1), and word address = io_address[ADDR_W+1:2].
REQ-015 SHALL implement an FSM with states IDLE, ACCESS, WAIT and DONE.
REQ-016 SHALL, in IDLE on io_write_strobe or io_read_strobe, latch address, slot, byte enables, write data and direction, then go to ACCESS; write wins when both strobes are high.
REQ-017 SHALL, on a strobe that misses the base, skip ACCESS/WAIT and go straight to DONE with read data 32'h0 and no bus activity.
REQ-018 SHALL ignore strobes in ACCESS, WAIT and DONE.
REQ-019 SHALL, in ACCESS, pulse b_wr or b_rd for exactly one cycle, one-hot b_cs[slot], and drive b_addr, b_be and b_wr_data from the latched values.
REQ-020 SHALL hold b_cs, b_addr, b_be and b_wr_data stable from ACCESS through WAIT; they are 0 in IDLE and DONE.
REQ-021 SHALL sample b_ack in ACCESS and WAIT; on b_ack it SHALL capture b_rd_data on reads and go to DONE.
REQ-022 SHALL count ACCESS+WAIT cycles; if the TIMEOUT-th such cycle has no b_ack, it SHALL go to DONE with read data 32'hDEAD_BEEF and increment timeout_cnt, saturating at 255.
REQ-023 SHALL treat b_ack on the TIMEOUT-th cycle as success (ack has priority over timeout).
REQ-024 SHALL assert io_ready for exactly one cycle, in DONE, and then return to IDLE.
REQ-025 SHALL register io_read_data: updated on entry to DONE for reads and misses, and held otherwise (held on writes).
REQ-026 SHALL give minimum latency as strobe at cycle T, b_wr/b_rd at T+1, ack at T+1, io_ready at T+2.
REQ-027 SHALL give worst-case latency (TIMEOUT=16) as io_ready at T+17.

Reset
REQ-028 SHALL, on reset assertion, immediately force IDLE with b_cs, b_wr, b_rd, b_be, b_addr, b_wr_data, io_ready, io_read_data and timeout_cnt all 0.
REQ-029 SHALL, on reset mid-transaction, abort the transaction without an io_ready pulse; the first strobe after reset release starts a fresh transaction.

Verification
REQ-030 SHALL verify: write strobe to addr 32'hC000_0010 with data 32'h1234_5678 and b_ack at T+1 -> b_cs=2'b01, b_addr=4, b_wr pulse at T+1, io_ready at T+2.
REQ-031 SHALL verify: read of 32'hC080_0008 with b_rd_data 32'hCAFE_F00D and b_ack at T+4 -> b_cs=2'b10, io_read_data=32'hCAFE_F00D, io_ready at T+5.
REQ-032 SHALL verify: read with b_ack never asserted -> io_ready at T+17, io_read_data=32'hDEAD_BEEF, timeout_cnt=1; 256 timeouts leave timeout_cnt=255.
REQ-033 SHALL verify: strobe to 32'h8000_0000 -> no b_cs/b_rd activity, io_ready at T+1, io_read_data=0.
REQ-034 SHALL verify: b_ack exactly on cycle T+16 -> success data returned and timeout_cnt unchanged.
REQ-035 SHALL verify: reset asserted in WAIT -> all outputs 0 asynchronously, no io_ready; the next read completes normally.
